// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: HH:MM:SS timekeeping with RUN/SET editing.
// Three debounced buttons (mode, pos, inc) drive a RUN/SET state machine that
// owns the time registers, the decimal-point mask and the blank mask.
// Optional feature macro: CLK_SET_BLINK_EN (blinks the selected field in SET).
module clock_set_ctrl #(
  parameter int DEB_CYC = 500000,
  parameter int DEB_W   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_mode,
  output logic [1:0] o_pos,
  output logic [5:0] o_dp,
  output logic [5:0] o_blank
);

  typedef enum logic {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;
  typedef enum logic [1:0] {F_SEC = 2'd0, F_MIN = 2'd1, F_HOUR = 2'd2} field_t;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  // Button index: 0 = mode, 1 = pos, 2 = inc
  logic [2:0]       raw;
  logic [2:0]       s1_q, s2_q, acc_q, press;
  logic [DEB_W-1:0] cnt_q [3];
  logic             mode_p, pos_p, inc_p;

  state_t     state_q, state_d;
  field_t     pos_q, pos_d;
  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] dp_q, blank_q, blank_d;
  logic [5:0] sec_inc, min_inc;
  logic [4:0] hour_inc;

  assign raw = {i_sw_inc, i_sw_pos, i_sw_mode};

  // Synchronise raw buttons and debounce each one against its accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      acc_q <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      for (int unsigned i = 0; i < 3; i++) begin
        if (s2_q[i] == acc_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          acc_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Press pulse in the cycle the accepted level rises
  always_comb begin
    press = '0;
    for (int unsigned i = 0; i < 3; i++)
      press[i] = s2_q[i] & ~acc_q[i] & (cnt_q[i] == DEB_LAST);
  end

  assign mode_p = press[0];
  assign pos_p  = press[1];
  assign inc_p  = press[2];

  function automatic logic [5:0] dp_mask(field_t f);
    case (f)
      F_MIN:   return 6'b000100;
      F_HOUR:  return 6'b010000;
      default: return 6'b000001;
    endcase
  endfunction

  function automatic logic [5:0] blank_mask(field_t f);
    case (f)
      F_MIN:   return 6'b001100;
      F_HOUR:  return 6'b110000;
      default: return 6'b000011;
    endcase
  endfunction

  // Next-state and next-time selection for the RUN/SET machine
  always_comb begin
    sec_inc  = (sec_q  == 6'd59) ? 6'd0 : sec_q  + 6'd1;
    min_inc  = (min_q  == 6'd59) ? 6'd0 : min_q  + 6'd1;
    hour_inc = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    state_d  = state_q;
    pos_d    = pos_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    case (state_q)
      ST_RUN: begin
        if (i_tick) begin
          sec_d = sec_inc;
          if (sec_q == 6'd59) begin
            min_d = min_inc;
            if (min_q == 6'd59) hour_d = hour_inc;
          end
        end
        if (mode_p) begin
          state_d = ST_SET;
          pos_d   = F_SEC;
        end
      end
      default: begin
        // Increment targets the field selected before any same-cycle pos press
        if (inc_p) begin
          case (pos_q)
            F_MIN:   min_d  = min_inc;
            F_HOUR:  hour_d = hour_inc;
            default: sec_d  = sec_inc;
          endcase
        end
        if (pos_p) begin
          case (pos_q)
            F_SEC:   pos_d = F_MIN;
            F_MIN:   pos_d = F_HOUR;
            default: pos_d = F_SEC;
          endcase
        end
        if (mode_p) state_d = ST_RUN;
      end
    endcase
  end

`ifdef CLK_SET_BLINK_EN
  logic blink_q, blink_d;

  // Blink flag: toggles per tick, forced visible on SET entry and on edits
  always_comb begin
    blink_d = blink_q;
    if (i_tick) blink_d = ~blink_q;
    if ((state_q == ST_RUN && mode_p) || inc_p || pos_p) blink_d = 1'b0;
    blank_d = (state_d == ST_SET && blink_d) ? blank_mask(pos_d) : '0;
  end

  // Blink flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= 1'b0;
    else        blink_q <= blink_d;
  end
`else
  always_comb blank_d = '0;
`endif

  // State machine registers with registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pos_q   <= F_SEC;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      dp_q    <= 6'b010100;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      dp_q    <= (state_d == ST_SET) ? dp_mask(pos_d) : 6'b010100;
      blank_q <= blank_d;
    end
  end

  assign o_sec   = sec_q;
  assign o_min   = min_q;
  assign o_hour  = hour_q;
  assign o_mode  = state_q;
  assign o_pos   = pos_q;
  assign o_dp    = dp_q;
  assign o_blank = blank_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a short debounce window.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [2:0] sw;   // 0 = mode, 1 = pos, 2 = inc
  logic [5:0] sec, min, dp, blank;
  logic [4:0] hour;
  logic       mode;
  logic [1:0] pos;

  int tests = 0;
  int fails = 0;

  localparam int BM = 0, BP = 1, BI = 2;

`ifdef CLK_SET_BLINK_EN
  localparam logic [5:0] BLANK_MIN = 6'b001100;
`else
  localparam logic [5:0] BLANK_MIN = 6'b000000;
`endif

  clock_set_ctrl #(.DEB_CYC(4), .DEB_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (tick),
    .i_sw_mode (sw[0]),
    .i_sw_pos  (sw[1]),
    .i_sw_inc  (sw[2]),
    .o_sec     (sec),
    .o_min     (min),
    .o_hour    (hour),
    .o_mode    (mode),
    .o_pos     (pos),
    .o_dp      (dp),
    .o_blank   (blank)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int b, input int n);
    repeat (n) begin
      sw[b] = 1'b1;
      cyc(10);
      sw[b] = 1'b0;
      cyc(10);
    end
  endtask

  task automatic tick_once();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, 32'(hour), 32'(h));
    chk({tag, "_min"},  32'(min),  32'(m));
    chk({tag, "_sec"},  32'(sec),  32'(s));
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    sw    = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Reset state
    chk_time("rst", 0, 0, 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_dp", 32'(dp), 32'h14);
    chk("rst_blank", 32'(blank), 0);

    // 1: three ticks in RUN
    repeat (3) tick_once();
    chk_time("t1", 0, 0, 3);
    chk("t1_mode", 32'(mode), 0);
    chk("t1_dp", 32'(dp), 32'h14);

    // 2: preload 23:59:58 through SET
    press(BM, 1);
    chk("t2_mode_set", 32'(mode), 1);
    chk("t2_pos_sec", 32'(pos), 0);
    chk("t2_dp_sec", 32'(dp), 32'h01);
    press(BI, 55);
    press(BP, 1);
    chk("t2_dp_min", 32'(dp), 32'h04);
    press(BI, 59);
    press(BP, 1);
    press(BI, 23);
    press(BM, 1);
    chk_time("t2_pre", 23, 59, 58);
    chk("t2_mode_run", 32'(mode), 0);
    chk("t2_pos_held", 32'(pos), 2);
    chk("t2_dp_run", 32'(dp), 32'h14);
    tick_once();
    chk_time("t2_a", 23, 59, 59);
    tick_once();
    chk_time("t2_b", 0, 0, 0);

    // 3: SET, select HOUR, 25 increments wrap to 1
    press(BM, 1);
    chk("t3_pos_sec", 32'(pos), 0);
    press(BP, 2);
    press(BI, 25);
    chk("t3_hour", 32'(hour), 1);
    chk("t3_pos", 32'(pos), 2);
    chk("t3_dp", 32'(dp), 32'h10);
    repeat (2) tick_once();
    chk_time("t3_frozen", 1, 0, 0);

    // 4: bouncing inc then a clean hold gives one increment
    repeat (5) begin
      sw[BI] = 1'b1;
      cyc(2);
      sw[BI] = 1'b0;
      cyc(2);
    end
    chk("t4_bounce", 32'(hour), 1);
    sw[BI] = 1'b1;
    cyc(10);
    sw[BI] = 1'b0;
    cyc(10);
    chk("t4_hour", 32'(hour), 2);

    // 5: build 00:00:59 in RUN, then tick and mode press land together
    press(BI, 22);
    press(BP, 1);
    chk("t5_pos_wrap", 32'(pos), 0);
    press(BI, 59);
    press(BM, 1);
    chk_time("t5_pre", 0, 0, 59);
    chk("t5_mode_run", 32'(mode), 0);
    sw[BM] = 1'b1;
    cyc(5);
    tick = 1'b1;       // lands on the edge where the mode press pulse is sampled
    cyc(1);
    tick = 1'b0;
    chk_time("t5_same", 0, 1, 0);
    chk("t5_mode_set", 32'(mode), 1);
    chk("t5_pos", 32'(pos), 0);
    sw[BM] = 1'b0;
    cyc(10);
    press(BI, 59);
    chk_time("t5_s59", 0, 1, 59);
    press(BI, 1);
    chk_time("t5_nocarry", 0, 1, 0);

    // 6: blink on the MIN field
    press(BP, 1);
    chk("t6_pos", 32'(pos), 1);
    chk("t6_dp", 32'(dp), 32'h04);
    chk("t6_blank0", 32'(blank), 0);
    tick_once();
    chk("t6_blank_tick", 32'(blank), 32'(BLANK_MIN));
    press(BI, 1);
    chk("t6_blank_inc", 32'(blank), 0);
    chk("t6_min", 32'(min), 2);

    // Reset while a button is held: must be re-accepted afterwards
    press(BM, 1);
    chk("rp_mode_run", 32'(mode), 0);
    sw[BM] = 1'b1;
    cyc(10);
    chk("rp_mode_set", 32'(mode), 1);
    rst_n = 1'b0;
    cyc(2);
    chk("rp_in_reset", 32'(mode), 0);
    rst_n = 1'b1;
    cyc(3);
    chk("rp_not_yet", 32'(mode), 0);
    cyc(5);
    chk("rp_reaccept", 32'(mode), 1);
    chk_time("rp_time", 0, 0, 0);
    sw[BM] = 1'b0;
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Bound on total run time
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
